// File: rtl/switch_allocator_if.sv
// Allocator-side bundle for the 5-port mesh router switch allocator.
// The router core (master) presents input-buffer heads and downstream
// readiness; the allocator (slave) returns pops, crossbar selects,
// output-valid flags and the sticky error.
// Optional macro SWALLOC_STATS_EN adds the per-output flit counters.
interface switch_allocator_if #(
    parameter int DEST_W = 3,
    parameter int CNT_W  = 16
);
    logic [4:0]          req;
    logic [4:0]          tail;
    logic [5*DEST_W-1:0] dest;
    logic [4:0]          out_ready;
    logic [4:0]          gnt;
    logic [4:0]          sel0;
    logic [4:0]          sel1;
    logic [4:0]          sel2;
    logic [4:0]          sel3;
    logic [4:0]          sel4;
    logic [4:0]          ovalid;
    logic                err;
`ifdef SWALLOC_STATS_EN
    logic [5*CNT_W-1:0]  flit_cnt;
`else
    logic [CNT_W-1:0]    cnt_unused;
    assign cnt_unused = '0;
`endif

    modport master (
        output req, tail, dest, out_ready,
        input  gnt, sel0, sel1, sel2, sel3, sel4, ovalid, err
`ifdef SWALLOC_STATS_EN
        , input flit_cnt
`endif
    );

    modport slave (
        input  req, tail, dest, out_ready,
        output gnt, sel0, sel1, sel2, sel3, sel4, ovalid, err
`ifdef SWALLOC_STATS_EN
        , output flit_cnt
`endif
    );
endinterface

// File: rtl/switch_allocator.sv
// Wormhole switch allocator for the 5-port mesh router
// (0 local, 1 north, 2 east, 3 south, 4 west).
// Each output is either free (round-robin among eligible heads that target
// it) or locked to one input until that input's tail flit is granted.
// Grants and crossbar selects are combinational; ovalid and err are
// registered. Defining SWALLOC_STATS_EN adds saturating per-output
// granted-flit counters on bus.flit_cnt.
module switch_allocator #(
    parameter int DEST_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    switch_allocator_if.slave   bus
);
    localparam int NP = 5;

    // Advance a port index modulo 5 (input range 0..9).
    function automatic logic [2:0] wrap5(input logic [3:0] v);
        logic [3:0] t;
        if (v >= 4'd5) begin
            t = v - 4'd5;
        end else begin
            t = v;
        end
        return t[2:0];
    endfunction

    logic [NP-1:0] lock_v_r;
    logic [2:0]    lock_id_r [NP];
    logic [2:0]    rr_r      [NP];
    logic [NP-1:0] ovalid_r;
    logic          err_r;

    logic [DEST_W-1:0] dest_s  [NP];
    logic [NP-1:0]     busy_s;
    logic [NP-1:0]     sel_s   [NP];
    logic [2:0]        win_s   [NP];
    logic [NP-1:0]     grant_s;
    logic [NP-1:0]     gnt_s;
    logic              err_hit_s;

    // Unpack per-input destinations and mark inputs that own a locked output.
    always_comb begin
        busy_s = '0;
        for (int i = 0; i < NP; i++) begin
            dest_s[i] = bus.dest[i*DEST_W +: DEST_W];
            for (int o = 0; o < NP; o++) begin
                busy_s[i] = busy_s[i] | (lock_v_r[o] & (lock_id_r[o] == 3'(i)));
            end
        end
    end

    // Per-output arbitration: locked owner pass-through or round-robin head pick.
    always_comb begin : p_arb
        logic [NP-1:0] cand;
        logic          found;
        logic [2:0]    idx;
        logic [2:0]    win;
        for (int o = 0; o < NP; o++) begin
            cand  = '0;
            found = 1'b0;
            idx   = 3'd0;
            win   = 3'd0;
            for (int i = 0; i < NP; i++) begin
                cand[i] = bus.req[i] & ~busy_s[i] & (dest_s[i] == DEST_W'(o));
            end
            if (lock_v_r[o]) begin
                win      = lock_id_r[o];
                sel_s[o] = (5'b00001 << lock_id_r[o]) & bus.req & {NP{bus.out_ready[o]}};
            end else begin
                for (int s = 0; s < NP; s++) begin
                    idx = wrap5({1'b0, rr_r[o]} + 4'(s));
                    if (!found && cand[idx]) begin
                        found = 1'b1;
                        win   = idx;
                    end else begin
                        found = found;
                    end
                end
                if (found && bus.out_ready[o]) begin
                    sel_s[o] = 5'b00001 << win;
                end else begin
                    sel_s[o] = 5'b00000;
                end
            end
            win_s[o]   = win;
            grant_s[o] = |sel_s[o];
        end
    end

    // Pop grants and illegal-destination detection for eligible heads.
    always_comb begin
        gnt_s     = '0;
        err_hit_s = 1'b0;
        for (int o = 0; o < NP; o++) begin
            gnt_s = gnt_s | sel_s[o];
        end
        for (int i = 0; i < NP; i++) begin
            err_hit_s = err_hit_s | (bus.req[i] & ~busy_s[i] & (dest_s[i] > DEST_W'(4)));
        end
    end

    // Lock, round-robin pointer, output-valid and sticky error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_v_r <= '0;
            ovalid_r <= '0;
            err_r    <= 1'b0;
            for (int o = 0; o < NP; o++) begin
                lock_id_r[o] <= 3'd0;
                rr_r[o]      <= 3'd0;
            end
        end else begin
            ovalid_r <= grant_s;
            err_r    <= err_r | err_hit_s;
            for (int o = 0; o < NP; o++) begin
                if (grant_s[o]) begin
                    if (lock_v_r[o]) begin
                        // Body/tail of the owning packet; only the tail releases.
                        if (bus.tail[win_s[o]]) begin
                            lock_v_r[o] <= 1'b0;
                        end
                    end else begin
                        rr_r[o] <= wrap5({1'b0, win_s[o]} + 4'd1);
                        // Single-flit packets never hold the output.
                        if (!bus.tail[win_s[o]]) begin
                            lock_v_r[o]  <= 1'b1;
                            lock_id_r[o] <= win_s[o];
                        end
                    end
                end
            end
        end
    end

    assign bus.gnt    = gnt_s;
    assign bus.sel0   = sel_s[0];
    assign bus.sel1   = sel_s[1];
    assign bus.sel2   = sel_s[2];
    assign bus.sel3   = sel_s[3];
    assign bus.sel4   = sel_s[4];
    assign bus.ovalid = ovalid_r;
    assign bus.err    = err_r;

`ifdef SWALLOC_STATS_EN
    logic [CNT_W-1:0] cnt_r [NP];

    // Count granted flits per output, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NP; o++) begin
                cnt_r[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (grant_s[o] && (cnt_r[o] != {CNT_W{1'b1}})) begin
                    cnt_r[o] <= cnt_r[o] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NP; g++) begin : g_cnt_out
        assign bus.flit_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
    end
`else
    logic [CNT_W-1:0] cnt_unused_s;
    assign cnt_unused_s = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator.
module tb_switch_allocator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    switch_allocator_if #(.DEST_W(3), .CNT_W(16)) bus();

    switch_allocator #(.DEST_W(3), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [14:0] pack_dest(input logic [2:0] d0, input logic [2:0] d1,
                                              input logic [2:0] d2, input logic [2:0] d3,
                                              input logic [2:0] d4);
        return {d4, d3, d2, d1, d0};
    endfunction

    task automatic drive(input logic [4:0] r, input logic [4:0] t,
                         input logic [14:0] d, input logic [4:0] rdy);
        bus.req       = r;
        bus.tail      = t;
        bus.dest      = d;
        bus.out_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        @(posedge clk);
        #3;
        n_run++;
        if (bus.gnt !== 5'b00000) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 5'b00000);
        end
        n_run++;
        if ({bus.sel0, bus.sel1, bus.sel2, bus.sel3, bus.sel4} !== 25'd0) begin
            n_fail++; $display("FAIL reset_sel: got %b expected 0",
                               {bus.sel0, bus.sel1, bus.sel2, bus.sel3, bus.sel4});
        end
        n_run++;
        if (bus.ovalid !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ovalid: got %b expected %b", bus.ovalid, 5'b00000);
        end
        n_run++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b expected %b", bus.err, 1'b0);
        end
    endtask

    // Input 1 sends head/body/tail to output 2; lock must release after the tail.
    task automatic test_packet();
        logic [4:0] exp_ov;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(5'b00010, (c == 2) ? 5'b00010 : 5'b00000,
                  pack_dest(3'd0, 3'd2, 3'd0, 3'd0, 3'd0), 5'b11111);
            exp_ov = (c == 0) ? 5'b00000 : 5'b00100;
            #3;
            n_run++;
            if (bus.sel2 !== 5'b00010 || bus.gnt !== 5'b00010) begin
                n_fail++; $display("FAIL packet_sel2 c%0d: got sel2=%b gnt=%b expected 00010/00010",
                                   c, bus.sel2, bus.gnt);
            end
            n_run++;
            if (bus.ovalid !== exp_ov) begin
                n_fail++; $display("FAIL packet_ovalid c%0d: got %b expected %b", c, bus.ovalid, exp_ov);
            end
            next_cycle();
        end
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        #3;
        n_run++;
        if (bus.gnt !== 5'b00000 || bus.ovalid !== 5'b00100) begin
            n_fail++; $display("FAIL packet_after_tail: got gnt=%b ovalid=%b expected 00000/00100",
                               bus.gnt, bus.ovalid);
        end
        next_cycle();
        drive(5'b01000, 5'b00000, pack_dest(3'd0, 3'd0, 3'd0, 3'd2, 3'd0), 5'b11111);
        #3;
        n_run++;
        if (bus.sel2 !== 5'b01000 || bus.ovalid !== 5'b00000) begin
            n_fail++; $display("FAIL packet_unlocked: got sel2=%b ovalid=%b expected 01000/00000",
                               bus.sel2, bus.ovalid);
        end
        next_cycle();
    endtask

    // Inputs 0, 3, 4 contend for output 1 with single-flit packets.
    task automatic test_round_robin();
        logic [4:0] exp_t [6];
        exp_t = '{5'b00001, 5'b01000, 5'b10000, 5'b00001, 5'b01000, 5'b10000};
        do_reset();
        drive(5'b11001, 5'b11001, pack_dest(3'd1, 3'd0, 3'd0, 3'd1, 3'd1), 5'b11111);
        for (int c = 0; c < 6; c++) begin
            #3;
            n_run++;
            if (bus.sel1 !== exp_t[c] || bus.gnt !== exp_t[c]) begin
                n_fail++; $display("FAIL rr_order c%0d: got sel1=%b gnt=%b expected %b",
                                   c, bus.sel1, bus.gnt, exp_t[c]);
            end
            next_cycle();
        end
    endtask

    // Input 0 holds output 3 for 4 flits; input 2 waits until after the tail.
    task automatic test_lock_block();
        logic [4:0]  req_t  [5];
        logic [4:0]  tail_t [5];
        logic [14:0] dest_t [5];
        logic [4:0]  exp_t  [5];
        req_t  = '{5'b00001, 5'b00001, 5'b00101, 5'b00101, 5'b00100};
        tail_t = '{5'b00000, 5'b00000, 5'b00100, 5'b00101, 5'b00100};
        dest_t = '{pack_dest(3'd3, 3'd0, 3'd0, 3'd0, 3'd0),
                   pack_dest(3'd7, 3'd0, 3'd0, 3'd0, 3'd0),
                   pack_dest(3'd3, 3'd0, 3'd3, 3'd0, 3'd0),
                   pack_dest(3'd3, 3'd0, 3'd3, 3'd0, 3'd0),
                   pack_dest(3'd0, 3'd0, 3'd3, 3'd0, 3'd0)};
        exp_t  = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00100};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(req_t[c], tail_t[c], dest_t[c], 5'b11111);
            #3;
            n_run++;
            if (bus.sel3 !== exp_t[c] || bus.gnt !== exp_t[c]) begin
                n_fail++; $display("FAIL lock_block c%0d: got sel3=%b gnt=%b expected %b",
                                   c, bus.sel3, bus.gnt, exp_t[c]);
            end
            next_cycle();
        end
        n_run++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL lock_body_dest_ignored: got err=%b expected 0", bus.err);
        end
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        next_cycle();
    endtask

    // Output 3 stalls for 2 cycles mid-packet; lock is held and the packet resumes.
    task automatic test_backpressure();
        logic [4:0]  req_t  [6];
        logic [4:0]  tail_t [6];
        logic [4:0]  rdy_t  [6];
        logic [4:0]  exp_t  [6];
        logic [4:0]  ov_t   [6];
        req_t  = '{5'b00001, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00010};
        tail_t = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00011, 5'b00010};
        rdy_t  = '{5'b11111, 5'b10111, 5'b10111, 5'b11111, 5'b11111, 5'b11111};
        exp_t  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00010};
        ov_t   = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b01000};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(req_t[c], tail_t[c], pack_dest(3'd3, 3'd3, 3'd0, 3'd0, 3'd0), rdy_t[c]);
            #3;
            n_run++;
            if (bus.sel3 !== exp_t[c] || bus.gnt !== exp_t[c]) begin
                n_fail++; $display("FAIL backpressure c%0d: got sel3=%b gnt=%b expected %b",
                                   c, bus.sel3, bus.gnt, exp_t[c]);
            end
            n_run++;
            if (bus.ovalid !== ov_t[c]) begin
                n_fail++; $display("FAIL backpressure_ovalid c%0d: got %b expected %b",
                                   c, bus.ovalid, ov_t[c]);
            end
            next_cycle();
        end
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        next_cycle();
    endtask

    // Input 4 targets illegal output 6; inputs 0 (U-turn) and 2 still use output 0.
    task automatic test_err();
        logic [4:0] exp_t [2];
        exp_t = '{5'b00001, 5'b00100};
        do_reset();
        drive(5'b10101, 5'b10101, pack_dest(3'd0, 3'd0, 3'd0, 3'd0, 3'd6), 5'b11111);
        for (int c = 0; c < 2; c++) begin
            #3;
            n_run++;
            if (bus.sel0 !== exp_t[c] || bus.gnt !== exp_t[c]) begin
                n_fail++; $display("FAIL err_others c%0d: got sel0=%b gnt=%b expected %b",
                                   c, bus.sel0, bus.gnt, exp_t[c]);
            end
            n_run++;
            if (bus.err !== ((c == 0) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL err_flag c%0d: got %b expected %b",
                                   c, bus.err, (c == 0) ? 1'b0 : 1'b1);
            end
            next_cycle();
        end
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        next_cycle();
        #3;
        n_run++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.err);
        end
        rst = 1'b0;
        #1;
        n_run++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL err_cleared: got %b expected 0", bus.err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reset in the middle of a packet on output 2, then a fresh head from input 3.
    task automatic test_reset_mid();
        do_reset();
        drive(5'b00010, 5'b00000, pack_dest(3'd0, 3'd2, 3'd0, 3'd0, 3'd0), 5'b11111);
        next_cycle();
        #3;
        n_run++;
        if (bus.ovalid !== 5'b00100 || bus.sel2 !== 5'b00010) begin
            n_fail++; $display("FAIL midreset_pre: got ovalid=%b sel2=%b expected 00100/00010",
                               bus.ovalid, bus.sel2);
        end
        #1;
        rst = 1'b0;
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        #1;
        n_run++;
        if (bus.ovalid !== 5'b00000 || bus.gnt !== 5'b00000 || bus.sel2 !== 5'b00000) begin
            n_fail++; $display("FAIL midreset_async: got ovalid=%b gnt=%b sel2=%b expected zeros",
                               bus.ovalid, bus.gnt, bus.sel2);
        end
        next_cycle();
        rst = 1'b1;
        drive(5'b01000, 5'b01000, pack_dest(3'd0, 3'd0, 3'd0, 3'd2, 3'd0), 5'b11111);
        #3;
        n_run++;
        if (bus.sel2 !== 5'b01000 || bus.gnt !== 5'b01000) begin
            n_fail++; $display("FAIL midreset_new_head: got sel2=%b gnt=%b expected 01000/01000",
                               bus.sel2, bus.gnt);
        end
        next_cycle();
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        next_cycle();
    endtask

    initial begin
        drive(5'b00000, 5'b00000, 15'd0, 5'b11111);
        test_reset();
        test_packet();
        test_round_robin();
        test_lock_block();
        test_backpressure();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
